// File: rtl/index_bound_filter.sv
// Multi-lane index bounds filter: gates lane values by x/y limits and a delayed accum_enable; 1-cycle latency,
// output register + skid register so in_ready drops one cycle after a stall. IDXCHK_DROP_EN: clear o_keep on bad lanes.
module index_bound_filter #(
   parameter int LANES      = 4,
   parameter int IDX_W      = 4,
   parameter int DATA_W     = 16,
   parameter int ENABLE_DLY = 1,
   parameter int CNT_W      = 16
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [IDX_W-1:0]                  x_limit,
   input  logic [IDX_W-1:0]                  y_limit,
   input  logic                              accum_enable,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [LANES*(2*IDX_W+2+DATA_W)-1:0] i_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [LANES*(2*IDX_W+DATA_W)-1:0] o_data,
   output logic [LANES-1:0]                  o_keep,
   input  logic                              clr_cnt,
   output logic [CNT_W-1:0]                  drop_cnt
);
   localparam int LW  = 2*IDX_W+2+DATA_W;
   localparam int OLW = 2*IDX_W+DATA_W;
   localparam int DW  = $clog2(LANES+1);

   logic en_d;

   generate
      if (ENABLE_DLY == 0) begin : g_no_dly
         assign en_d = accum_enable;
      end else begin : g_dly
         logic [ENABLE_DLY-1:0] en_sr;
         // Free-running delay line; it never waits on a handshake.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               en_sr <= '0;
            end else begin
               en_sr[0] <= accum_enable;
               for (int i = 1; i < ENABLE_DLY; i++) en_sr[i] <= en_sr[i-1];
            end
         end
         assign en_d = en_sr[ENABLE_DLY-1];
      end
   endgenerate

   logic [LANES*OLW-1:0] proc_dat;
   logic [LANES-1:0]     proc_keep;
   logic [LANES-1:0]     lane_bad;
   logic [DW-1:0]        proc_drops;
   logic                 proc_present;

   genvar k;
   generate
      for (k = 0; k < LANES; k++) begin : g_lane
         logic [IDX_W:0]    x_raw;
         logic [IDX_W:0]    y_raw;
         logic [DATA_W-1:0] val;
         logic              in_rng;
         assign x_raw  = i_data[k*LW+DATA_W+IDX_W+1 +: IDX_W+1];
         assign y_raw  = i_data[k*LW+DATA_W +: IDX_W+1];
         assign val    = i_data[k*LW +: DATA_W];
         assign in_rng = !x_raw[IDX_W] && !y_raw[IDX_W] &&
                         (x_raw[IDX_W-1:0] <= x_limit) && (y_raw[IDX_W-1:0] <= y_limit);
         assign lane_bad[k] = !in_rng;
`ifdef IDXCHK_DROP_EN
         assign proc_keep[k] = in_rng;
         assign proc_dat[k*OLW +: OLW] = in_rng ?
            {x_raw[IDX_W-1:0], y_raw[IDX_W-1:0], (en_d ? val : {DATA_W{1'b0}})} : {OLW{1'b0}};
`else
         assign proc_keep[k] = 1'b1;
         assign proc_dat[k*OLW +: OLW] =
            {x_raw[IDX_W-1:0], y_raw[IDX_W-1:0], ((in_rng && en_d) ? val : {DATA_W{1'b0}})};
`endif
      end
   endgenerate

`ifdef IDXCHK_DROP_EN
   assign proc_present = |proc_keep;
`else
   assign proc_present = 1'b1;
`endif

   always_comb begin
      proc_drops = '0;
      for (int i = 0; i < LANES; i++) proc_drops = proc_drops + DW'(lane_bad[i]);
   end

   logic                 skid_vld;
   logic [LANES*OLW-1:0] skid_dat;
   logic [LANES-1:0]     skid_keep;
   logic                 accept;
   logic                 load;
   logic                 take;

   assign in_ready = !skid_vld;
   assign accept   = in_valid && in_ready;
   assign load     = accept && proc_present;
   assign take     = out_valid && out_ready;

   // Skid full implies in_ready low, so a skid refill never coincides with a new load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         o_data    <= '0;
         o_keep    <= '0;
         skid_vld  <= 1'b0;
         skid_dat  <= '0;
         skid_keep <= '0;
      end else if (take && skid_vld) begin
         out_valid <= 1'b1;
         o_data    <= skid_dat;
         o_keep    <= skid_keep;
         skid_vld  <= 1'b0;
      end else if (load && (!out_valid || out_ready)) begin
         out_valid <= 1'b1;
         o_data    <= proc_dat;
         o_keep    <= proc_keep;
      end else if (load) begin
         skid_vld  <= 1'b1;
         skid_dat  <= proc_dat;
         skid_keep <= proc_keep;
      end else if (take) begin
         out_valid <= 1'b0;
      end
   end

   logic [CNT_W:0] cnt_sum;
   assign cnt_sum = {1'b0, drop_cnt} + (CNT_W+1)'(proc_drops);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         drop_cnt <= '0;
      else if (clr_cnt)
         drop_cnt <= '0;
      else if (accept)
         drop_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end
endmodule

// File: tb/tb_index_bound_filter.sv
// Randomised self-checking bench for index_bound_filter against a lane-level behavioural model.
module tb_index_bound_filter;
   localparam int LANES = 4, IDX_W = 4, DATA_W = 16, ENABLE_DLY = 1, CNT_W = 16;
   localparam int LW = 2*IDX_W+2+DATA_W;
   localparam int OLW = 2*IDX_W+DATA_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset_n;
   logic [IDX_W-1:0] x_limit, y_limit;
   logic accum_enable, in_valid, in_ready, out_valid, out_ready, clr_cnt;
   logic [LANES*LW-1:0] i_data;
   logic [LANES*OLW-1:0] o_data;
   logic [LANES-1:0] o_keep;
   logic [CNT_W-1:0] drop_cnt;

   index_bound_filter #(.LANES(LANES), .IDX_W(IDX_W), .DATA_W(DATA_W),
                        .ENABLE_DLY(ENABLE_DLY), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .x_limit(x_limit), .y_limit(y_limit),
      .accum_enable(accum_enable), .in_valid(in_valid), .in_ready(in_ready), .i_data(i_data),
      .out_valid(out_valid), .out_ready(out_ready), .o_data(o_data), .o_keep(o_keep),
      .clr_cnt(clr_cnt), .drop_cnt(drop_cnt));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [LANES*OLW-1:0] dat;
      logic [LANES-1:0]     keep;
   } beat_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   logic  en_hist[$];
   int    model_cnt = 0;
   int    checks = 0;
   int    failures = 0;
   bit    last_acc;

   function automatic logic [LW-1:0] mk_lane(input int xr, input int yr, input int v);
      return LW'(xr * (1 << (IDX_W+1+DATA_W)) + yr * (1 << DATA_W) + v);
   endfunction

   // Expected beat from the lane rules: range test, enable gating, keep/drop policy.
   function automatic void model_beat(input logic [LANES*LW-1:0] d, input int xl, input int yl,
                                      input logic en, output beat_t b, output bit present,
                                      output int ndrop);
      b = '0; present = 0; ndrop = 0;
      for (int k = 0; k < LANES; k++) begin
         int xr, yr, v, xm, ym, ov;
         bit ok;
         v  = int'(d[k*LW +: DATA_W]);
         yr = int'(d[k*LW+DATA_W +: IDX_W+1]);
         xr = int'(d[k*LW+DATA_W+IDX_W+1 +: IDX_W+1]);
         xm = xr % (1 << IDX_W);
         ym = yr % (1 << IDX_W);
         ok = (xr < (1 << IDX_W)) && (yr < (1 << IDX_W)) && (xm <= xl) && (ym <= yl);
         if (!ok) ndrop++;
         ov = xm * (1 << (IDX_W+DATA_W)) + ym * (1 << DATA_W) + ((ok && en) ? v : 0);
`ifdef IDXCHK_DROP_EN
         b.keep[k] = ok;
         if (ok) begin
            b.dat[k*OLW +: OLW] = OLW'(ov);
            present = 1;
         end
`else
         b.keep[k] = 1'b1;
         b.dat[k*OLW +: OLW] = OLW'(ov);
         present = 1;
`endif
      end
   endfunction

   // One clock: observe handshakes just after the negedge, advance to the next negedge.
   task automatic cycle();
      beat_t b;
      bit pres;
      int nd;
      logic en;
      #1;
      if (out_valid && out_ready) got_q.push_back(beat_t'({o_data, o_keep}));
      last_acc = in_valid && in_ready;
      if (last_acc) begin
         if (ENABLE_DLY == 0) en = accum_enable;
         else en = (en_hist.size() >= ENABLE_DLY) ? en_hist[en_hist.size()-ENABLE_DLY] : 1'b0;
         model_beat(i_data, int'(x_limit), int'(y_limit), en, b, pres, nd);
         if (pres) exp_q.push_back(b);
         model_cnt = (model_cnt + nd > CNT_MAX) ? CNT_MAX : model_cnt + nd;
      end
      if (clr_cnt) model_cnt = 0;
      @(posedge clk);
      en_hist.push_back(accum_enable);
      if (en_hist.size() > 8) void'(en_hist.pop_front());
      @(negedge clk);
   endtask

   task automatic drain(output bit timed_out);
      in_valid = 0; out_ready = 1; clr_cnt = 0;
      timed_out = 1;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid) begin
            timed_out = 0;
            break;
         end
         cycle();
      end
   endtask

   task automatic test_reset();
      reset_n = 0; accum_enable = 0; in_valid = 0; out_ready = 1; clr_cnt = 0;
      x_limit = 4'd9; y_limit = 4'd9; i_data = '0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
      checks++; if ({o_data, o_keep} !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {o_data, o_keep}); end
      @(negedge clk); @(negedge clk);
      reset_n = 1;
   endtask

   task automatic test_pass();
      bit to;
      accum_enable = 1; in_valid = 0;
      cycle(); cycle();
      i_data = '0;
      i_data[0 +: LW] = mk_lane(3, 9, 16'h1234);
      in_valid = 1; out_ready = 1;
      cycle();
      in_valid = 0;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pass_latency out_valid got=%b exp=1", out_valid); end
      checks++; if (o_data[0 +: OLW] !== 24'h391234) begin failures++; $display("FAIL pass_lane0 got=%h exp=391234", o_data[0 +: OLW]); end
      drain(to);
      checks++; if (to) begin failures++; $display("FAIL pass_drain timeout"); end
      checks++;
      if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         failures++; $display("FAIL pass_model got_n=%0d exp_n=%0d", got_q.size(), exp_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_range();
      bit to;
      logic [3:0] exp_keep;
      clr_cnt = 1; in_valid = 0;
      cycle();
      clr_cnt = 0;
      i_data[0*LW +: LW] = mk_lane(3, 9, 16'h1111);
      i_data[1*LW +: LW] = mk_lane(10, 2, 16'h2222);
      i_data[2*LW +: LW] = mk_lane(1, 5'h13, 16'h3333);
      i_data[3*LW +: LW] = mk_lane(9, 0, 16'h4444);
      in_valid = 1;
      cycle();
      in_valid = 0;
      #1;
`ifdef IDXCHK_DROP_EN
      exp_keep = 4'b1001;
      checks++; if (o_data[OLW +: 2*OLW] !== 48'h0) begin failures++; $display("FAIL range_bad_lanes got=%h exp=0", o_data[OLW +: 2*OLW]); end
`else
      exp_keep = 4'b1111;
      checks++; if (o_data[OLW +: 2*OLW] !== 48'h130000_A20000) begin failures++; $display("FAIL range_bad_lanes got=%h exp=130000a20000", o_data[OLW +: 2*OLW]); end
`endif
      checks++; if (o_keep !== exp_keep) begin failures++; $display("FAIL range_keep got=%b exp=%b", o_keep, exp_keep); end
      checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL range_drop_cnt got=%0d exp=2", drop_cnt); end
      checks++; if (o_data[3*OLW +: DATA_W] !== 16'h4444) begin failures++; $display("FAIL range_lane3 got=%h exp=4444", o_data[3*OLW +: DATA_W]); end
      drain(to);
      checks++; if (to) begin failures++; $display("FAIL range_drain timeout"); end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_enable_pulse();
      bit to;
      int vals[4];
      accum_enable = 0; in_valid = 0;
      cycle(); cycle();
      for (int b = 0; b < 4; b++) begin
         vals[b] = $urandom_range(1, 16'hFFFF);
         for (int k = 0; k < LANES; k++) i_data[k*LW +: LW] = mk_lane(k, 2, vals[b]);
         accum_enable = (b == 0);
         in_valid = 1; out_ready = 1;
         cycle();
      end
      accum_enable = 0;
      drain(to);
      checks++; if (to || got_q.size() != 4) begin failures++; $display("FAIL pulse_count got=%0d exp=4", got_q.size()); end
      for (int b = 0; b < 4 && b < got_q.size(); b++) begin
         checks++;
         if (got_q[b].dat[0 +: DATA_W] !== ((b == 1) ? vals[b][DATA_W-1:0] : 16'h0)) begin
            failures++; $display("FAIL pulse_beat%0d value got=%h", b, got_q[b].dat[0 +: DATA_W]);
         end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_backpressure();
      bit to;
      int nacc;
      logic [LANES*OLW-1:0] held;
      accum_enable = 1; out_ready = 0; nacc = 0;
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < LANES; k++) i_data[k*LW +: LW] = mk_lane($urandom_range(0, 9), $urandom_range(0, 9), $urandom);
         in_valid = 1;
         cycle();
         if (last_acc) nacc++;
         if (b == 0) held = o_data;
      end
      #1;
      checks++; if (nacc != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", nacc); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b1 || o_data !== held) begin failures++; $display("FAIL bp_hold got=%h exp=%h", o_data, held); end
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_acc) break;
      end
      checks++; if (!last_acc) begin failures++; $display("FAIL bp_third_beat not accepted"); end
      drain(to);
      checks++; if (to || got_q.size() != 3 || exp_q.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_order beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_saturation();
      bit to;
      clr_cnt = 1; in_valid = 0; out_ready = 1;
      cycle();
      clr_cnt = 0;
      for (int k = 0; k < LANES; k++) i_data[k*LW +: LW] = mk_lane(5'h1F, 0, 16'h5A5A);
      in_valid = 1;
      cycle();
      checks++; if (drop_cnt !== 16'd4) begin failures++; $display("FAIL sat_first got=%0d exp=4", drop_cnt); end
      for (int i = 0; i < 16383; i++) cycle();
      checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%0d exp=65535", drop_cnt); end
      cycle();
      checks++; if (drop_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0d exp=65535", drop_cnt); end
      clr_cnt = 1;
      cycle();
      clr_cnt = 0;
      checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL sat_clr_wins got=%0d exp=0", drop_cnt); end
      drain(to);
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      bit to;
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         accum_enable = $urandom_range(0, 1);
         clr_cnt = ($urandom_range(0, 40) == 0);
         x_limit = $urandom_range(0, 15);
         y_limit = $urandom_range(0, 15);
         for (int k = 0; k < LANES; k++)
            i_data[k*LW +: LW] = mk_lane($urandom_range(0, 15) + (($urandom_range(0, 7) == 0) ? 16 : 0),
                                         $urandom_range(0, 15) + (($urandom_range(0, 7) == 0) ? 16 : 0),
                                         $urandom_range(0, 16'hFFFF));
         cycle();
      end
      drain(to);
      checks++; if (to || got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (int'(drop_cnt) != model_cnt) begin failures++; $display("FAIL rand_drop_cnt got=%0d exp=%0d", drop_cnt, model_cnt); end
      got_q.delete(); exp_q.delete();
      x_limit = 4'd9; y_limit = 4'd9;
   endtask

   task automatic test_midreset();
      bit to;
      accum_enable = 1; out_ready = 0;
      for (int k = 0; k < LANES; k++) i_data[k*LW +: LW] = mk_lane(12, 1, 16'h0BAD);
      in_valid = 1;
      cycle(); cycle();
      in_valid = 0;
      #2 reset_n = 0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL midrst_drop_cnt got=%0d exp=0", drop_cnt); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      got_q.delete(); exp_q.delete(); en_hist.delete(); model_cnt = 0;
      @(negedge clk);
      reset_n = 1;
      for (int k = 0; k < LANES; k++) i_data[k*LW +: LW] = mk_lane(2, 2, 16'h7777);
      in_valid = 1; out_ready = 1;
      cycle();
      drain(to);
      checks++;
      if (to || got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].dat[0 +: DATA_W] !== 16'h0) begin
         failures++; $display("FAIL midrst_enable_flushed got_n=%0d", got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_range();
      test_enable_pulse();
      test_backpressure();
      test_saturation();
      test_random();
      test_midreset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
